// File: rtl/pill_target_entry_pkg.sv
// +--------------------------------------------------------------------------+
// | pill_target_entry_pkg: shared FSM encoding, cursor indices, BCD helpers   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pill_target_entry_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_EDIT   = 2'd1,
    ST_ARMED  = 2'd2
  } state_t;

  // Cursor index doubles as the bit position in cursor_mask.
  localparam logic [2:0] CUR_P3 = 3'd4;
  localparam logic [2:0] CUR_P2 = 3'd3;
  localparam logic [2:0] CUR_P1 = 3'd2;
  localparam logic [2:0] CUR_B2 = 3'd1;
  localparam logic [2:0] CUR_B1 = 3'd0;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int unsigned NUM_KEYS  = 4;
  localparam int unsigned KEY_INC   = 0;
  localparam int unsigned KEY_SEL   = 1;
  localparam int unsigned KEY_CLR   = 2;
  localparam int unsigned KEY_START = 3;

  function automatic logic [3:0] bcd_inc(input logic [3:0] digit);
    return (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
  endfunction

  function automatic logic [4:0] cursor_to_mask(input logic [2:0] cur);
    return 5'b00001 << cur;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pill_target_entry_btn_debounce.sv
// +--------------------------------------------------------------------------+
// | btn_debounce: 2-FF sync, hold-time filter and one-cycle press pulse       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic             filt_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      press_q    <= filt_q & ~filt_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/pill_target_entry.sv
// +--------------------------------------------------------------------------+
// | pill_target_entry: operator key entry of BCD pill/bottle targets          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pill_target_entry
  import pill_target_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter logic [11:0] DEF_PILLS       = 12'h000,
  parameter logic [7:0]  DEF_BOTTLES     = 8'h00
) (
  input  logic        clk_1khz,
  input  logic        rst_n,
  input  logic        setting_en,
  input  logic        btn_inc,
  input  logic        btn_sel,
  input  logic        btn_clr,
  input  logic        btn_start,
  output logic [11:0] target_pills,
  output logic [7:0]  target_bottles,
  output logic [4:0]  cursor_mask,
  output logic        start_req,
  output logic        start_reject,
  output logic        cfg_locked
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_evt;

  assign key_raw[KEY_INC]   = btn_inc;
  assign key_raw[KEY_SEL]   = btn_sel;
  assign key_raw[KEY_CLR]   = btn_clr;
  assign key_raw[KEY_START] = btn_start;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (clk_1khz),
      .rst_ni (rst_n),
      .btn_i  (key_raw[k]),
      .press_o(key_evt[k])
    );
  end

  state_t      state_q, state_d;
  logic [2:0]  cursor_q, cursor_d;
  logic [11:0] pills_q, pills_d;
  logic [7:0]  bottles_q, bottles_d;
  logic [4:0]  mask_q, mask_d;
  logic        req_q, req_d;
  logic        rej_q, rej_d;
  logic        locked_q, locked_d;

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    pills_d   = pills_q;
    bottles_d = bottles_q;
    req_d     = 1'b0;
    rej_d     = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (setting_en) begin
          state_d  = ST_EDIT;
          cursor_d = CUR_P3;
        end
      end
      ST_EDIT: begin
        // Leaving SETTING takes precedence; any coincident key is dropped.
        if (!setting_en) begin
          state_d = ST_LOCKED;
        end else if (key_evt[KEY_CLR]) begin
          pills_d   = DEF_PILLS;
          bottles_d = DEF_BOTTLES;
          cursor_d  = CUR_P3;
        end else if (key_evt[KEY_START]) begin
          if ((pills_q == 12'h000) || (bottles_q == 8'h00)) begin
            rej_d = 1'b1;
          end else begin
            req_d   = 1'b1;
            state_d = ST_ARMED;
          end
        end else if (key_evt[KEY_SEL]) begin
          cursor_d = (cursor_q == CUR_B1) ? CUR_P3 : cursor_q - 3'd1;
        end else if (key_evt[KEY_INC]) begin
          case (cursor_q)
            CUR_P3:  pills_d[11:8]  = bcd_inc(pills_q[11:8]);
            CUR_P2:  pills_d[7:4]   = bcd_inc(pills_q[7:4]);
            CUR_P1:  pills_d[3:0]   = bcd_inc(pills_q[3:0]);
            CUR_B2:  bottles_d[7:4] = bcd_inc(bottles_q[7:4]);
            CUR_B1:  bottles_d[3:0] = bcd_inc(bottles_q[3:0]);
            default: ;
          endcase
        end
      end
      ST_ARMED: begin
        if (!setting_en) begin
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase

    mask_d   = (state_d == ST_EDIT) ? cursor_to_mask(cursor_d) : 5'b00000;
    locked_d = (state_d != ST_EDIT);
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOCKED;
      cursor_q  <= CUR_P3;
      pills_q   <= DEF_PILLS;
      bottles_q <= DEF_BOTTLES;
      mask_q    <= 5'b00000;
      req_q     <= 1'b0;
      rej_q     <= 1'b0;
      locked_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      pills_q   <= pills_d;
      bottles_q <= bottles_d;
      mask_q    <= mask_d;
      req_q     <= req_d;
      rej_q     <= rej_d;
      locked_q  <= locked_d;
    end
  end

  assign target_pills   = pills_q;
  assign target_bottles = bottles_q;
  assign cursor_mask    = mask_q;
  assign start_req      = req_q;
  assign start_reject   = rej_q;
  assign cfg_locked     = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_pill_target_entry.sv
// +--------------------------------------------------------------------------+
// | tb_pill_target_entry: directed self-checking bench for pill_target_entry  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pill_target_entry;

  logic        clk_1khz;
  logic        rst_n;
  logic        setting_en;
  logic [3:0]  keys;
  logic [11:0] target_pills;
  logic [7:0]  target_bottles;
  logic [4:0]  cursor_mask;
  logic        start_req;
  logic        start_reject;
  logic        cfg_locked;

  int n_checks = 0;
  int n_fails  = 0;
  int req_cnt  = 0;
  int rej_cnt  = 0;
  int req_base;
  int rej_base;

  localparam int K_INC = 0, K_SEL = 1, K_CLR = 2, K_START = 3;

  pill_target_entry #(
    .DEBOUNCE_CYCLES(4),
    .DEF_PILLS      (12'h000),
    .DEF_BOTTLES    (8'h00)
  ) dut (
    .clk_1khz      (clk_1khz),
    .rst_n         (rst_n),
    .setting_en    (setting_en),
    .btn_inc       (keys[K_INC]),
    .btn_sel       (keys[K_SEL]),
    .btn_clr       (keys[K_CLR]),
    .btn_start     (keys[K_START]),
    .target_pills  (target_pills),
    .target_bottles(target_bottles),
    .cursor_mask   (cursor_mask),
    .start_req     (start_req),
    .start_reject  (start_reject),
    .cfg_locked    (cfg_locked)
  );

  initial begin
    clk_1khz = 1'b0;
    forever #5 clk_1khz = ~clk_1khz;
  end

  always @(negedge clk_1khz) begin
    if (start_req)    req_cnt <= req_cnt + 1;
    if (start_reject) rej_cnt <= rej_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  // Raw key held 7 cycles then released long enough for the filter to drop.
  task automatic press(input logic [3:0] which);
    keys = which;
    tick(7);
    keys = 4'b0000;
    tick(10);
  endtask

  task automatic press_n(input int k, input int n);
    for (int i = 0; i < n; i++) press(4'(1 << k));
  endtask

  initial begin
    rst_n      = 1'b0;
    setting_en = 1'b0;
    keys       = 4'b0000;
    tick(3);
    check("rst_pills",   32'(target_pills),   32'h000);
    check("rst_bottles", 32'(target_bottles), 32'h00);
    check("rst_mask",    32'(cursor_mask),    32'h00);
    check("rst_req",     32'(start_req),      32'h0);
    check("rst_rej",     32'(start_reject),   32'h0);
    check("rst_locked",  32'(cfg_locked),     32'h1);

    rst_n = 1'b1;
    tick(2);
    check("locked_idle_mask", 32'(cursor_mask), 32'h00);
    setting_en = 1'b1;
    tick(2);
    check("edit_mask",    32'(cursor_mask),    32'h10);
    check("edit_locked",  32'(cfg_locked),     32'h0);
    check("edit_pills",   32'(target_pills),   32'h000);
    check("edit_bottles", 32'(target_bottles), 32'h00);

    press_n(K_INC, 3);
    check("inc3_pills", 32'(target_pills), 32'h300);
    press_n(K_SEL, 2);
    press_n(K_INC, 1);
    check("p1_pills", 32'(target_pills), 32'h301);
    check("p1_mask",  32'(cursor_mask),  32'h04);

    press_n(K_INC, 8);
    check("p1_nine", 32'(target_pills), 32'h309);
    press_n(K_INC, 1);
    check("p1_wrap_nocarry", 32'(target_pills), 32'h300);

    press_n(K_SEL, 1);
    check("sel_b2", 32'(cursor_mask), 32'h02);
    press_n(K_SEL, 2);
    check("sel_back_p3", 32'(cursor_mask), 32'h10);
    press_n(K_SEL, 5);
    check("sel5_p3", 32'(cursor_mask), 32'h10);

    req_base = req_cnt;
    rej_base = rej_cnt;
    press(4'(1 << K_START));
    check("reject_pulse", 32'(rej_cnt - rej_base), 32'd1);
    check("reject_noreq", 32'(req_cnt - req_base), 32'd0);
    check("reject_mask",  32'(cursor_mask),        32'h10);
    check("reject_lock",  32'(cfg_locked),         32'h0);

    press_n(K_SEL, 4);
    check("sel_b1", 32'(cursor_mask), 32'h01);
    press_n(K_INC, 5);
    check("bottles05", 32'(target_bottles), 32'h05);

    req_base = req_cnt;
    rej_base = rej_cnt;
    press(4'(1 << K_START));
    check("start_pulse",  32'(req_cnt - req_base), 32'd1);
    check("start_norej",  32'(rej_cnt - rej_base), 32'd0);
    check("armed_locked", 32'(cfg_locked),         32'h1);
    check("armed_mask",   32'(cursor_mask),        32'h00);
    press_n(K_INC, 1);
    press(4'(1 << K_START));
    check("armed_bottles", 32'(target_bottles),     32'h05);
    check("armed_pills",   32'(target_pills),       32'h300);
    check("armed_noreq",   32'(req_cnt - req_base), 32'd1);

    setting_en = 1'b0;
    tick(2);
    check("locked_again", 32'(cfg_locked), 32'h1);
    setting_en = 1'b1;
    tick(2);
    check("reedit_mask",    32'(cursor_mask),    32'h10);
    check("reedit_pills",   32'(target_pills),   32'h300);
    check("reedit_bottles", 32'(target_bottles), 32'h05);

    keys[K_INC] = 1'b1;
    tick(2);
    keys[K_INC] = 1'b0;
    tick(12);
    check("glitch_pills", 32'(target_pills), 32'h300);

    press(4'((1 << K_CLR) | (1 << K_INC)));
    check("clr_pills",   32'(target_pills),   32'h000);
    check("clr_bottles", 32'(target_bottles), 32'h00);
    check("clr_mask",    32'(cursor_mask),    32'h10);

    press_n(K_INC, 2);
    press_n(K_SEL, 1);
    press_n(K_INC, 5);
    check("pills250", 32'(target_pills), 32'h250);

    req_base = req_cnt;
    keys[K_START] = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_pills",  32'(target_pills), 32'h000);
    check("async_mask",   32'(cursor_mask),  32'h00);
    check("async_locked", 32'(cfg_locked),   32'h1);
    check("async_req",    32'(start_req),    32'h0);
    keys = 4'b0000;
    tick(5);
    rst_n = 1'b1;
    tick(20);
    check("post_rst_noreq", 32'(req_cnt - req_base), 32'd0);
    check("post_rst_pills", 32'(target_pills),       32'h000);
    check("post_rst_mask",  32'(cursor_mask),        32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
